// File: rtl/pcie_scram_pkg.sv
// Shared definitions for the Gen3 128b/130b multi-lane scrambler:
// seed table, feedback tap mask, symbol-kind encodings and the
// byte-wide LFSR advance used by every lane.
package pcie_scram_pkg;

   localparam int LFSR_W = 23;

   // Feedback positions of X^23+X^21+X^16+X^8+X^5+X^2+1 after a left shift
   localparam logic [LFSR_W-1:0] TAP_MASK = 23'h210125;

   typedef enum logic [1:0] {
      KIND_DATA  = 2'b00,
      KIND_OS    = 2'b01,
      KIND_SKP   = 2'b10,
      KIND_EIEOS = 2'b11
   } kind_e;

   // Per-physical-lane seed; the table repeats every eight lanes
   function automatic logic [LFSR_W-1:0] seedFor(input int idx);
      logic [LFSR_W-1:0] seed;
      case (idx % 8)
         0:       seed = 23'h1DBFBC;
         1:       seed = 23'h0607BB;
         2:       seed = 23'h1EC760;
         3:       seed = 23'h18C0DB;
         4:       seed = 23'h010F12;
         5:       seed = 23'h19CFC9;
         6:       seed = 23'h0277CE;
         default: seed = 23'h1BB807;
      endcase
      return seed;
   endfunction

   // Advance the LFSR eight bits; returns {next state, key byte} with key
   // bit 0 being the first bit produced (and therefore the first transmitted)
   function automatic logic [LFSR_W+7:0] lfsrStep8(input logic [LFSR_W-1:0] state);
      logic [LFSR_W-1:0] s;
      logic [7:0]        key;
      s   = state;
      key = '0;
      for (int b = 0; b < 8; b++) begin
         key[b] = s[LFSR_W-1];
         s      = {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? TAP_MASK : '0);
      end
      return {s, key};
   endfunction

endpackage

// File: rtl/lfsr23_lane.sv
// One lane of the Gen3 scrambler: the 23-bit LFSR register, its seed
// reload, and a chain of byte stages that scramble SYM_W bits per beat.
// The scrambled data is combinational; the top registers it.
module lfsr23_lane
   import pcie_scram_pkg::*;
#(
   parameter int                SYM_W = 8,
   parameter logic [LFSR_W-1:0] SEED  = 23'h1DBFBC
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   lfsr_ld_i,
   input  logic                   accept_i,
   input  logic                   en_scram_i,
   input  logic [SYM_W-1:0]       data_i,
   input  logic [2*(SYM_W/8)-1:0] kind_i,
   output logic [SYM_W-1:0]       data_o
);

   localparam int NBYTES = SYM_W / 8;

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] chainState;
   logic [LFSR_W+7:0] stepRes;
   logic              sawEieos;

   // Byte chain: a reload request means this beat starts from the seed;
   // SKP bytes leave the LFSR untouched, every other kind consumes 8 key bits
   always_comb begin
      chainState = lfsr_ld_i ? SEED : lfsr_q;
      stepRes    = '0;
      sawEieos   = 1'b0;
      data_o     = data_i;
      lfsr_d     = lfsr_q;
      for (int j = 0; j < NBYTES; j++) begin
         if (kind_i[2*j +: 2] != KIND_SKP) begin
            stepRes    = lfsrStep8(chainState);
            chainState = stepRes[LFSR_W+7:8];
            if (kind_i[2*j +: 2] == KIND_DATA && en_scram_i) begin
               data_o[8*j +: 8] = data_i[8*j +: 8] ^ stepRes[7:0];
            end
            if (kind_i[2*j +: 2] == KIND_EIEOS) begin
               sawEieos = 1'b1;
            end
         end
      end
      if (accept_i) begin
         lfsr_d = sawEieos ? SEED : chainState;
      end else if (lfsr_ld_i) begin
         lfsr_d = SEED;
      end
   end

   // LFSR register; reset returns the lane to its seed
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

endmodule

// File: rtl/scrambler_multilane_gen3.sv
// Multi-lane PCIe Gen3 scrambler: LANES independent lane scramblers
// behind a single valid/ready handshake and one output register stage.
module scrambler_multilane_gen3
   import pcie_scram_pkg::*;
#(
   parameter int LANES     = 4,
   parameter int SYM_W     = 8,
   parameter int LANE_BASE = 0
) (
   input  logic                         clk_1G,
   input  logic                         rst_1G,
   input  logic                         lfsr_ld,
   input  logic                         en_scram,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*SYM_W-1:0]       in_data,
   input  logic [LANES*2*(SYM_W/8)-1:0] in_kind,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [LANES*SYM_W-1:0]       out_data,
   output logic [LANES*2*(SYM_W/8)-1:0] out_kind
);

   localparam int KW_LANE = 2 * (SYM_W / 8);

   logic                         outValid_q;
   logic                         outValid_d;
   logic [LANES*SYM_W-1:0]       outData_q;
   logic [LANES*SYM_W-1:0]       outData_d;
   logic [LANES*KW_LANE-1:0]     outKind_q;
   logic [LANES*KW_LANE-1:0]     outKind_d;
   logic [LANES*SYM_W-1:0]       scrData;
   logic                         accept;

   assign in_ready  = !outValid_q | out_ready;
   assign accept    = in_valid & in_ready;
   assign out_valid = outValid_q;
   assign out_data  = outData_q;
   assign out_kind  = outKind_q;

   for (genvar n = 0; n < LANES; n++) begin : gLane
      lfsr23_lane #(
         .SYM_W (SYM_W),
         .SEED  (seedFor(LANE_BASE + n))
      ) uLane (
         .clk_i      (clk_1G),
         .rst_ni     (rst_1G),
         .lfsr_ld_i  (lfsr_ld),
         .accept_i   (accept),
         .en_scram_i (en_scram),
         .data_i     (in_data[n*SYM_W +: SYM_W]),
         .kind_i     (in_kind[n*KW_LANE +: KW_LANE]),
         .data_o     (scrData[n*SYM_W +: SYM_W])
      );
   end

   // Output stage: load on accept, drain when downstream takes the beat,
   // otherwise hold so data stays stable under backpressure
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outKind_d  = outKind_q;
      if (accept) begin
         outValid_d = 1'b1;
         outData_d  = scrData;
         outKind_d  = in_kind;
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register; reset drops any in-flight beat
   always_ff @(posedge clk_1G) begin
      if (!rst_1G) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outKind_q  <= '0;
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outKind_q  <= outKind_d;
      end
   end

endmodule
